// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: control-bit positions inside the
// EX/MEM control buses, access-size encodings, and lane-decode helpers.
package mem_stage_pkg;

  // in_mem bit positions
  localparam int unsigned MEM_BRANCH    = 2;
  localparam int unsigned MEM_READ      = 1;
  localparam int unsigned MEM_WRITE     = 0;

  // in_wb bit positions
  localparam int unsigned WB_REG_WRITE  = 1;
  localparam int unsigned WB_MEM_TO_REG = 0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11   // behaves as a word access
  } mem_size_t;

  function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction

  // Big-endian lanes: offset 0 is bits [31:24], i.e. byte-enable bit 3.
  function automatic logic [3:0] lane_enables(input mem_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_enables = 4'b1000 >> off;
      SZ_HALF: lane_enables = off[1] ? 4'b0011 : 4'b1100;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: dual-port word RAM with synchronous reads.
//   Port A: read/write, per-byte write enables (be_a[i] covers bits [8i+7:8i]).
//   Port B: read-only.
// Reads return the contents before any same-edge write. Contents are not
// cleared by reset; only the read registers are.
module data_memory #(
  parameter int unsigned NB_data     = 32,
  parameter int unsigned NB_mem_addr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NB_mem_addr-1:0] addr_a,
  input  logic [NB_data/8-1:0]   be_a,
  input  logic [NB_data-1:0]     wdata_a,
  output logic [NB_data-1:0]     rdata_a,
  input  logic [NB_mem_addr-1:0] addr_b,
  output logic [NB_data-1:0]     rdata_b
);

  logic [NB_data-1:0] ram [2**NB_mem_addr];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB_data/8; i++) begin
      if (be_a[i]) ram[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= ram[addr_a];
      rdata_b <= ram[addr_b];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage and MEM/WB pipeline register.
//   in_alu/in_w_data/in_mem_size/in_mem_unsigned : load/store request
//   in_mem [branch,mem_read,mem_write], in_wb [reg_write,mem_to_reg]
//   in_zero/in_branch -> out_pcsrc/out_pc_branch_addr (combinational)
//   out_read_data/out_alu/out_reg_dest/out_wb/out_misaligned : MEM/WB
//   in_dbg_addr -> out_dbg_data : independent word read, one cycle latency
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned NB_data     = 32,
  parameter int unsigned NB_addr     = 5,
  parameter int unsigned NB_mem_addr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NB_data-1:0]     in_alu,
  input  logic [NB_data-1:0]     in_w_data,
  input  logic [NB_addr-1:0]     in_reg_dest,
  input  logic [2:0]             in_mem,
  input  logic [1:0]             in_wb,
  input  logic [1:0]             in_mem_size,
  input  logic                   in_mem_unsigned,
  input  logic                   in_zero,
  input  logic [NB_data-1:0]     in_branch,
  input  logic [NB_mem_addr-1:0] in_dbg_addr,
  output logic                   out_pcsrc,
  output logic [NB_data-1:0]     out_pc_branch_addr,
  output logic [NB_data-1:0]     out_read_data,
  output logic [NB_data-1:0]     out_alu,
  output logic [NB_addr-1:0]     out_reg_dest,
  output logic [1:0]             out_wb,
  output logic                   out_misaligned,
  output logic [NB_data-1:0]     out_dbg_data
);

  mem_stage_pkg::mem_size_t sz;
  logic [1:0]             off;
  logic [NB_mem_addr-1:0] word_addr;
  logic                   mis;
  logic                   do_store;
  logic                   do_load;
  logic [3:0]             be;
  logic [NB_data-1:0]     wdata;
  logic [NB_data-1:0]     ram_rdata;
  logic                   unused_addr_bits;

  // Load-format fields registered alongside the synchronous RAM read
  logic      ld_valid;
  mem_size_t ld_size;
  logic      ld_unsigned;
  logic [1:0] ld_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign out_pcsrc          = in_mem[MEM_BRANCH] & in_zero;
  assign out_pc_branch_addr = in_branch;

  assign sz               = mem_size_t'(in_mem_size);
  assign off              = in_alu[1:0];
  assign word_addr        = in_alu[NB_mem_addr+1:2];
  assign unused_addr_bits = ^in_alu[NB_data-1:NB_mem_addr+2];

  assign mis      = (in_mem[MEM_READ] | in_mem[MEM_WRITE]) & is_misaligned(sz, off);
  assign do_store = reset & in_mem[MEM_WRITE] & ~mis;
  // A simultaneous read+write request is a store only.
  assign do_load  = in_mem[MEM_READ] & ~in_mem[MEM_WRITE] & ~mis;
  assign be       = do_store ? lane_enables(sz, off) : '0;

  always_comb begin
    wdata = in_w_data;
    case (sz)
      SZ_BYTE: wdata = {4{in_w_data[7:0]}};
      SZ_HALF: wdata = {2{in_w_data[15:0]}};
      default: wdata = in_w_data;
    endcase
  end

  data_memory #(
    .NB_data     (NB_data),
    .NB_mem_addr (NB_mem_addr)
  ) u_data_memory (
    .clk     (clk),
    .reset   (reset),
    .addr_a  (word_addr),
    .be_a    (be),
    .wdata_a (wdata),
    .rdata_a (ram_rdata),
    .addr_b  (in_dbg_addr),
    .rdata_b (out_dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_valid       <= 1'b0;
      ld_size        <= SZ_WORD;
      ld_unsigned    <= 1'b0;
      ld_off         <= '0;
      out_alu        <= '0;
      out_reg_dest   <= '0;
      out_wb         <= '0;
      out_misaligned <= 1'b0;
    end else begin
      ld_valid       <= do_load;
      ld_size        <= sz;
      ld_unsigned    <= in_mem_unsigned;
      ld_off         <= off;
      out_alu        <= in_alu;
      out_reg_dest   <= in_reg_dest;
      out_wb         <= {in_wb[WB_REG_WRITE] & ~mis, in_wb[WB_MEM_TO_REG]};
      out_misaligned <= mis;
    end
  end

  // Offset 0 is the most significant byte, so the lane base is (3-off)*8.
  assign ld_byte = ram_rdata[{~ld_off, 3'b000} +: 8];
  assign ld_half = ld_off[1] ? ram_rdata[15:0] : ram_rdata[31:16];

  always_comb begin
    out_read_data = '0;
    if (ld_valid) begin
      case (ld_size)
        SZ_BYTE: out_read_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
        SZ_HALF: out_read_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
        default: out_read_data = ram_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_alu, in_w_data, in_branch;
  logic [4:0]  in_reg_dest;
  logic [2:0]  in_mem;
  logic [1:0]  in_wb, in_mem_size;
  logic        in_mem_unsigned, in_zero;
  logic [9:0]  in_dbg_addr;
  logic        out_pcsrc, out_misaligned;
  logic [31:0] out_pc_branch_addr, out_read_data, out_alu, out_dbg_data;
  logic [4:0]  out_reg_dest;
  logic [1:0]  out_wb;

  // Reference model: byte-addressed big-endian memory (4 KiB)
  logic [7:0] mb [4096];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.NB_data(32), .NB_addr(5), .NB_mem_addr(10)) dut (
    .clk(clk), .reset(reset), .in_alu(in_alu), .in_w_data(in_w_data),
    .in_reg_dest(in_reg_dest), .in_mem(in_mem), .in_wb(in_wb),
    .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
    .in_zero(in_zero), .in_branch(in_branch), .in_dbg_addr(in_dbg_addr),
    .out_pcsrc(out_pcsrc), .out_pc_branch_addr(out_pc_branch_addr),
    .out_read_data(out_read_data), .out_alu(out_alu),
    .out_reg_dest(out_reg_dest), .out_wb(out_wb),
    .out_misaligned(out_misaligned), .out_dbg_data(out_dbg_data)
  );

  // Expectations derived from never-written memory are unknown and skipped.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    if ($isunknown(exp)) return;
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] mem,
                     input logic [1:0] wb, input logic [1:0] size, input logic uns,
                     input logic [9:0] dbg);
    in_alu = alu; in_w_data = wd; in_mem = mem; in_wb = wb;
    in_mem_size = size; in_mem_unsigned = uns; in_dbg_addr = dbg;
  endtask

  // Apply current inputs for one clock, predicting all outputs from the model.
  task automatic cycle(input string tag);
    logic [31:0] e_rd, e_dbg, e_alu, v;
    logic [4:0]  e_dest;
    logic [1:0]  e_wb;
    logic        e_mis, rd, wr;
    int          n, a, d;
    #1;
    chk({tag, ":pcsrc"}, {31'b0, out_pcsrc}, {31'b0, in_mem[2] & in_zero});
    chk({tag, ":br_addr"}, out_pc_branch_addr, in_branch);
    d = int'(in_dbg_addr) * 4;
    if (!reset) begin
      e_rd = '0; e_dbg = '0; e_alu = '0; e_dest = '0; e_wb = '0; e_mis = 1'b0;
    end else begin
      e_dbg  = {mb[d], mb[d+1], mb[d+2], mb[d+3]};
      n      = (in_mem_size == 2'd0) ? 1 : (in_mem_size == 2'd1) ? 2 : 4;
      a      = int'(in_alu[11:0]);
      rd     = in_mem[1];
      wr     = in_mem[0];
      e_mis  = (rd | wr) && (a % n != 0);
      e_rd   = '0;
      if (rd && !wr && !e_mis) begin
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mb[a+i]);
        if (!in_mem_unsigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e_rd = v;
      end
      if (wr && !e_mis)
        for (int i = 0; i < n; i++) mb[a+i] = 8'(in_w_data >> (8*(n-1-i)));
      e_alu  = in_alu;
      e_dest = in_reg_dest;
      e_wb   = {in_wb[1] & ~e_mis, in_wb[0]};
    end
    @(posedge clk);
    #1;
    chk({tag, ":read_data"}, out_read_data, e_rd);
    chk({tag, ":alu"}, out_alu, e_alu);
    chk({tag, ":reg_dest"}, {27'b0, out_reg_dest}, {27'b0, e_dest});
    chk({tag, ":wb"}, {30'b0, out_wb}, {30'b0, e_wb});
    chk({tag, ":misaligned"}, {31'b0, out_misaligned}, {31'b0, e_mis});
    chk({tag, ":dbg"}, out_dbg_data, e_dbg);
  endtask

  initial begin
    reset = 1'b0; in_reg_dest = 5'd7; in_zero = 1'b0; in_branch = 32'h0000_0100;
    drv(32'h10, 32'h0, 3'b010, 2'b10, 2'd2, 1'b0, 10'd0);
    @(negedge clk);
    cycle("reset0");
    cycle("reset1");
    reset = 1'b1;

    // Populate bytes 0..63 so the random phase only touches known contents
    for (int w = 0; w < 16; w++) begin
      drv(32'(w*4), $urandom, 3'b001, 2'b00, 2'd2, 1'b0, 10'(w));
      cycle("prefill");
    end

    drv(32'h10, 32'hDEAD_BEEF, 3'b001, 2'b00, 2'd2, 1'b0, 10'd4); cycle("st_w");
    drv(32'h10, 32'h0, 3'b010, 2'b11, 2'd2, 1'b0, 10'd4);         cycle("ld_w");
    chk("ld_w_const", out_read_data, 32'hDEAD_BEEF);
    chk("ld_w_wb", {30'b0, out_wb}, 32'd3);
    chk("ld_w_alu", out_alu, 32'h10);

    drv(32'h10, 32'h0, 3'b001, 2'b00, 2'd2, 1'b0, 10'd4);         cycle("st_zero");
    drv(32'h13, 32'h80, 3'b001, 2'b00, 2'd0, 1'b0, 10'd4);        cycle("st_b");
    drv(32'h13, 32'h0, 3'b010, 2'b11, 2'd0, 1'b0, 10'd4);         cycle("ld_bs");
    chk("ld_bs_const", out_read_data, 32'hFFFF_FF80);
    drv(32'h13, 32'h0, 3'b010, 2'b11, 2'd0, 1'b1, 10'd4);         cycle("ld_bu");
    chk("ld_bu_const", out_read_data, 32'h0000_0080);
    drv(32'h10, 32'h0, 3'b010, 2'b11, 2'd2, 1'b0, 10'd4);         cycle("ld_w2");
    chk("ld_w2_const", out_read_data, 32'h0000_0080);

    drv(32'h11, 32'h0, 3'b010, 2'b10, 2'd1, 1'b0, 10'd4);         cycle("mis_ld_h");
    chk("mis_ld_h_flag", {31'b0, out_misaligned}, 32'd1);
    drv(32'h12, 32'hCAFE_F00D, 3'b001, 2'b10, 2'd2, 1'b0, 10'd4); cycle("mis_st_w");
    chk("mis_st_w_wb", {30'b0, out_wb}, 32'd0);
    drv(32'h0, 32'h0, 3'b000, 2'b00, 2'd2, 1'b0, 10'd4);          cycle("mis_dbg");
    chk("mis_dbg_const", out_dbg_data, 32'h0000_0080);

    in_branch = 32'h0000_0440; in_zero = 1'b1;
    drv(32'h0, 32'h0, 3'b100, 2'b00, 2'd2, 1'b0, 10'd0);          cycle("br_taken");
    in_zero = 1'b0;                                               cycle("br_not");

    drv(32'h1000, 32'h1234_5678, 3'b001, 2'b00, 2'd2, 1'b0, 10'd0); cycle("st_wrap");
    drv(32'h0, 32'h0, 3'b000, 2'b00, 2'd2, 1'b0, 10'd0);            cycle("dbg_wrap");
    chk("dbg_wrap_const", out_dbg_data, 32'h1234_5678);

    drv(32'h20, 32'hA5A5_A5A5, 3'b001, 2'b00, 2'd2, 1'b0, 10'd8);   cycle("rbw_st");
    drv(32'h20, 32'h0, 3'b000, 2'b00, 2'd2, 1'b0, 10'd8);           cycle("rbw_after");

    drv(32'h20, 32'h5555_5555, 3'b011, 2'b10, 2'd2, 1'b0, 10'd8);   cycle("rw_both");
    drv(32'h20, 32'h0, 3'b010, 2'b10, 2'd2, 1'b0, 10'd8);           cycle("rw_check");

    reset = 1'b0;
    drv(32'h24, 32'hFFFF_FFFF, 3'b001, 2'b10, 2'd2, 1'b0, 10'd9);   cycle("rst_st");
    reset = 1'b1;
    drv(32'h24, 32'h0, 3'b000, 2'b00, 2'd2, 1'b0, 10'd9);           cycle("rst_dbg");

    for (int k = 0; k < 500; k++) begin
      in_reg_dest = 5'($urandom);
      in_zero     = 1'($urandom);
      in_branch   = $urandom;
      drv(($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom,
          3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
          10'($urandom_range(0, 15)));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the EX stage. It consumes the EX/MEM outputs (ALU result, store data, destination register, MEM/WB control bits), performs byte/half/word loads and stores on an internal data memory, resolves the branch decision, and registers everything into the MEM/WB boundary for the write-back stage.

## Interface
- NB_data, 32, datapath width
- NB_addr, 5, register-file address width
- NB_mem_addr, 10, data-memory word-address width (2^10 words = 4 KiB)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; when reset==0 at a rising edge, the block resets
- in_alu  in  NB_data  EX ALU result; byte address for loads/stores
- in_w_data  in  NB_data  store data (rt value from EX)
- in_reg_dest  in  NB_addr  destination register from EX
- in_mem  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
- in_wb  in  2  [1]=reg_write, [0]=mem_to_reg
- in_mem_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
- in_mem_unsigned  in  1  1=zero-extend loads, 0=sign-extend
- in_zero  in  1  ALU zero flag from EX
- in_branch  in  NB_data  branch target from EX
- in_dbg_addr  in  NB_mem_addr  debug word-read address
- out_pcsrc  out  1  combinational: in_mem[2] & in_zero
- out_pc_branch_addr  out  NB_data  combinational pass-through of in_branch
- out_read_data  out  NB_data  extended load data (MEM/WB)
- out_alu  out  NB_data  registered in_alu
- out_reg_dest  out  NB_addr  registered in_reg_dest
- out_wb  out  2  registered in_wb, reg_write gated on misalignment
- out_misaligned  out  1  registered misaligned-access flag
- out_dbg_data  out  NB_data  debug word read, one cycle latency

## Operation
- Word address = in_alu[NB_mem_addr+1:2]; higher bits ignored (address wraps modulo memory size). Byte offset = in_alu[1:0]; MIPS big-endian: offset 0 = bits [31:24].
- Misaligned: half with offset[0]=1, word with offset!=0. Access (read or write) with misalignment: store suppressed, out_read_data=0, out_misaligned=1, out_wb[1] forced 0.
- Store: byte writes in_w_data[7:0] into lane selected by offset; half writes in_w_data[15:0] into lanes {0,1} or {2,3}; word writes all lanes. Unselected lanes unchanged.
- Load: memory word read synchronously; lane/size/unsigned and offset registered alongside; out_read_data extracted/extended combinationally from RAM output and those registered fields.
- mem_read and mem_write both 1: treated as store only; out_read_data=0.
- Neither set: no memory access; out_read_data=0.
- Memory contents not cleared by reset; writes suppressed while reset==0.
- Debug port read is independent of the pipeline port; same-address write in same cycle returns old data (read-before-write).

## Timing
- Latency: one cycle EX/MEM inputs -> all MEM/WB outputs.
- Store visible to a load issued the next cycle.
- Load in cycle N to address just stored in cycle N: returns old data.
- Reset values: out_read_data, out_alu, out_dbg_data=0; out_reg_dest=0; out_wb=00; out_misaligned=0. Combinational out_pcsrc/out_pc_branch_addr follow inputs even during reset.
- No stall/flush; one access per cycle, every cycle.

## Structure
- Shared package: in_mem bit indices (MEM_BRANCH=2, MEM_READ=1, MEM_WRITE=0), in_wb indices (WB_REG_WRITE=1, WB_MEM_TO_REG=0), size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
- Sub-module data_memory: dual-port RAM, port A read/write with 4-bit byte-enable, port B read-only; both synchronous read.
- Top: address/lane decode, byte-enable and store-data replication, MEM/WB register, load extract/extend.

## Test plan
- Reset held low 2 cycles with in_mem=010, in_wb=10 -> all registered outputs 0, no memory write; release -> outputs track inputs next cycle.
- Store word 0xDEADBEEF at 0x10, then load word 0x10 -> out_read_data=0xDEADBEEF, out_wb=in_wb, out_alu=0x10.
- Store byte 0x80 at 0x13 over 0x00000000, then load byte signed 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word 0x10 -> 0x00000080.
- Load half at 0x11, store word at 0x12 -> out_misaligned=1, out_wb[1]=0, out_read_data=0, memory at 0x10 unchanged (checked via in_dbg_addr=4 -> out_dbg_data).
- in_mem=100, in_zero=1 -> out_pcsrc=1 same cycle, out_pc_branch_addr=in_branch; in_zero=0 -> out_pcsrc=0.
- Store word 0x12345678 at 0x1000 (wraps to 0x0) -> debug read address 0 returns 0x12345678.
